// File: rtl/pipe_hazard_ctl_if.sv
// Pipeline hazard control bus: decode-stage control in, stage controls and hazard signals out.
// Optional counters exist only when PIPE_HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [1:0]            i_result_src_d;
    logic                  i_branch_d;
    logic                  i_jmp_d;
    logic                  i_mem_write_d;
    logic                  i_reg_write_d;
    logic [2:0]            i_alu_ctl_d;
    logic                  i_alu_src_d;
    logic [REG_ADDR_W-1:0] i_rs1_d;
    logic [REG_ADDR_W-1:0] i_rs2_d;
    logic [REG_ADDR_W-1:0] i_rd_d;
    logic                  i_zero_e;
    logic                  i_hold;
    logic                  o_stall_f;
    logic                  o_stall_d;
    logic                  o_flush_d;
    logic                  o_flush_e;
    logic                  o_pc_src_e;
    logic [1:0]            o_fwd_a_e;
    logic [1:0]            o_fwd_b_e;
    logic [2:0]            o_alu_ctl_e;
    logic                  o_alu_src_e;
    logic                  o_mem_write_m;
    logic [1:0]            o_result_src_w;
    logic                  o_reg_write_w;
    logic [REG_ADDR_W-1:0] o_rd_w;
`ifdef PIPE_HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]      o_stall_cnt;
    logic [CNT_W-1:0]      o_flush_cnt;
`endif

    modport master (
`ifdef PIPE_HAZ_PERF_CNT_EN
        input  o_stall_cnt, o_flush_cnt,
`endif
        output i_result_src_d, i_branch_d, i_jmp_d, i_mem_write_d, i_reg_write_d,
        output i_alu_ctl_d, i_alu_src_d, i_rs1_d, i_rs2_d, i_rd_d, i_zero_e, i_hold,
        input  o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_pc_src_e, o_fwd_a_e, o_fwd_b_e,
        input  o_alu_ctl_e, o_alu_src_e, o_mem_write_m, o_result_src_w, o_reg_write_w, o_rd_w
    );

    modport slave (
`ifdef PIPE_HAZ_PERF_CNT_EN
        output o_stall_cnt, o_flush_cnt,
`endif
        input  i_result_src_d, i_branch_d, i_jmp_d, i_mem_write_d, i_reg_write_d,
        input  i_alu_ctl_d, i_alu_src_d, i_rs1_d, i_rs2_d, i_rd_d, i_zero_e, i_hold,
        output o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_pc_src_e, o_fwd_a_e, o_fwd_b_e,
        output o_alu_ctl_e, o_alu_src_e, o_mem_write_m, o_result_src_w, o_reg_write_w, o_rd_w
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Pipeline control sequencing for the 5-stage RV32I core: carries decode control through
// E/M/W, detects load-use hazards, flushes on taken branch/jump, selects forwarding and
// freezes on external hold. Define PIPE_HAZ_PERF_CNT_EN to add stall/flush counters.
module pipe_hazard_ctl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipe_hazard_ctl_if.slave   bus
);
    typedef struct packed {
        logic [1:0]            result_src;
        logic                  branch;
        logic                  jmp;
        logic                  mem_write;
        logic                  reg_write;
        logic [2:0]            alu_ctl;
        logic                  alu_src;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } e_stage_t;

    typedef struct packed {
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic [1:0]            result_src;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } w_stage_t;

    e_stage_t e_q, e_d;
    m_stage_t m_q;
    w_stage_t w_q;
    logic     lw_stall;
    logic     pc_src;
    logic     flush_e;

    // M has priority: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic m_rw, input logic [REG_ADDR_W-1:0] m_rd,
                                           input logic w_rw, input logic [REG_ADDR_W-1:0] w_rd);
        if (m_rw && (m_rd != '0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_rw && (w_rd != '0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Hazard detection and stall/flush generation; hold overrides both.
    always_comb begin
        lw_stall = (e_q.result_src == 2'b01) && (e_q.rd != '0) &&
                   ((e_q.rd == bus.i_rs1_d) || (e_q.rd == bus.i_rs2_d));
        pc_src   = e_q.jmp | (e_q.branch & bus.i_zero_e);
        flush_e  = ~bus.i_hold & (lw_stall | pc_src);
    end

    // Next E contents: a bubble on flush, otherwise the decode-stage control.
    always_comb begin
        e_d = '0;
        if (!flush_e) begin
            e_d.result_src = bus.i_result_src_d;
            e_d.branch     = bus.i_branch_d;
            e_d.jmp        = bus.i_jmp_d;
            e_d.mem_write  = bus.i_mem_write_d;
            e_d.reg_write  = bus.i_reg_write_d;
            e_d.alu_ctl    = bus.i_alu_ctl_d;
            e_d.alu_src    = bus.i_alu_src_d;
            e_d.rs1        = bus.i_rs1_d;
            e_d.rs2        = bus.i_rs2_d;
            e_d.rd         = bus.i_rd_d;
        end
    end

    // Stage registers advance together unless held; reset loads bubbles everywhere.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!bus.i_hold) begin
            e_q <= e_d;
            m_q <= '{result_src: e_q.result_src, mem_write: e_q.mem_write,
                     reg_write: e_q.reg_write, rd: e_q.rd};
            w_q <= '{result_src: m_q.result_src, reg_write: m_q.reg_write, rd: m_q.rd};
        end
    end

    // Output decode from stage registers and current inputs.
    always_comb begin
        bus.o_stall_f      = bus.i_hold | lw_stall;
        bus.o_stall_d      = bus.i_hold | lw_stall;
        bus.o_flush_d      = ~bus.i_hold & pc_src;
        bus.o_flush_e      = flush_e;
        bus.o_pc_src_e     = pc_src;
        bus.o_fwd_a_e      = fwd_sel(e_q.rs1, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
        bus.o_fwd_b_e      = fwd_sel(e_q.rs2, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
        bus.o_alu_ctl_e    = e_q.alu_ctl;
        bus.o_alu_src_e    = e_q.alu_src;
        bus.o_mem_write_m  = m_q.mem_write;
        bus.o_result_src_w = w_q.result_src;
        bus.o_reg_write_w  = w_q.reg_write;
        bus.o_rd_w         = w_q.rd;
    end

`ifdef PIPE_HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters; held cycles are not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.i_hold) begin
            if (lw_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (pc_src && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: scoreboard queue of stage contents.
module tb_pipe_hazard_ctl;
    typedef struct packed {
        logic [1:0] result_src;
        logic       branch;
        logic       jmp;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] alu_ctl;
        logic       alu_src;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       zero;
    } instr_t;

    localparam int N = 18;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_stall = 0;
    int     n_flush = 0;
    instr_t prog [N];
    instr_t q [$];
    instr_t w_m;
    instr_t bub;

    pipe_hazard_ctl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    pipe_hazard_ctl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic instr_t mk(input logic [1:0] rsrc, input logic br, input logic jp,
                                  input logic mw, input logic rw, input logic [2:0] alu,
                                  input logic asrc, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic z);
        instr_t t;
        t = '{result_src: rsrc, branch: br, jmp: jp, mem_write: mw, reg_write: rw,
              alu_ctl: alu, alu_src: asrc, rs1: rs1, rs2: rs2, rd: rd, zero: z};
        return t;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs, input instr_t m, input instr_t w);
        if (m.reg_write && m.rd != 0 && m.rd == rs) return 2'b10;
        if (w.reg_write && w.rd != 0 && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back(bub);
        q.push_back(bub);
        w_m = bub;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stall_f"}, 32'(bus.o_stall_f), 0);
        check_val({tag, "_stall_d"}, 32'(bus.o_stall_d), 0);
        check_val({tag, "_flush_d"}, 32'(bus.o_flush_d), 0);
        check_val({tag, "_flush_e"}, 32'(bus.o_flush_e), 0);
        check_val({tag, "_pc_src"}, 32'(bus.o_pc_src_e), 0);
        check_val({tag, "_fwd"}, 32'({bus.o_fwd_a_e, bus.o_fwd_b_e}), 0);
        check_val({tag, "_alu_e"}, 32'({bus.o_alu_ctl_e, bus.o_alu_src_e}), 0);
        check_val({tag, "_mem_write_m"}, 32'(bus.o_mem_write_m), 0);
        check_val({tag, "_w"}, 32'({bus.o_result_src_w, bus.o_reg_write_w, bus.o_rd_w}), 0);
    endtask

    // One clock: drive decode, check outputs at negedge, advance the scoreboard at posedge.
    task automatic step(input instr_t d, input logic hold_in, output logic lw, output logic pc);
        instr_t e, m;
        m = q[0];
        e = q[1];
        bus.i_result_src_d = d.result_src;
        bus.i_branch_d     = d.branch;
        bus.i_jmp_d        = d.jmp;
        bus.i_mem_write_d  = d.mem_write;
        bus.i_reg_write_d  = d.reg_write;
        bus.i_alu_ctl_d    = d.alu_ctl;
        bus.i_alu_src_d    = d.alu_src;
        bus.i_rs1_d        = d.rs1;
        bus.i_rs2_d        = d.rs2;
        bus.i_rd_d         = d.rd;
        bus.i_zero_e       = e.zero;
        bus.i_hold         = hold_in;
        @(negedge clk);
        lw = (e.result_src == 2'b01) && (e.rd != 0) && (e.rd == d.rs1 || e.rd == d.rs2);
        pc = e.jmp | (e.branch & e.zero);
        check_val("stall_f", 32'(bus.o_stall_f), 32'(hold_in | lw));
        check_val("stall_d", 32'(bus.o_stall_d), 32'(hold_in | lw));
        check_val("flush_d", 32'(bus.o_flush_d), 32'(!hold_in & pc));
        check_val("flush_e", 32'(bus.o_flush_e), 32'(!hold_in & (lw | pc)));
        check_val("pc_src_e", 32'(bus.o_pc_src_e), 32'(pc));
        check_val("fwd_a_e", 32'(bus.o_fwd_a_e), 32'(fwd_exp(e.rs1, m, w_m)));
        check_val("fwd_b_e", 32'(bus.o_fwd_b_e), 32'(fwd_exp(e.rs2, m, w_m)));
        check_val("alu_ctl_e", 32'(bus.o_alu_ctl_e), 32'(e.alu_ctl));
        check_val("alu_src_e", 32'(bus.o_alu_src_e), 32'(e.alu_src));
        check_val("mem_write_m", 32'(bus.o_mem_write_m), 32'(m.mem_write));
        check_val("result_src_w", 32'(bus.o_result_src_w), 32'(w_m.result_src));
        check_val("reg_write_w", 32'(bus.o_reg_write_w), 32'(w_m.reg_write));
        check_val("rd_w", 32'(bus.o_rd_w), 32'(w_m.rd));
        @(posedge clk);
        if (!hold_in) begin
            w_m = q.pop_front();
            q.push_back((lw | pc) ? bub : d);
        end
        #1;
    endtask

    initial begin
        int     idx;
        int     hold_left;
        logic   dbub, held_done, h, lw, pc;
        instr_t d, rd5;

        bub = '0;
        prog[0]  = mk(2'd0, 0, 0, 0, 1, 3'd0, 1, 5'd1,  5'd0, 5'd3,  0);
        prog[1]  = mk(2'd0, 0, 0, 0, 1, 3'd1, 1, 5'd2,  5'd0, 5'd3,  0);
        prog[2]  = mk(2'd0, 0, 0, 0, 1, 3'd2, 0, 5'd3,  5'd3, 5'd4,  0); // M and W both write x3
        prog[3]  = mk(2'd0, 0, 0, 0, 1, 3'd3, 0, 5'd2,  5'd1, 5'd5,  0);
        prog[4]  = mk(2'd0, 0, 0, 1, 0, 3'd0, 1, 5'd4,  5'd6, 5'd0,  0); // only W writes x4
        prog[5]  = mk(2'd0, 0, 0, 0, 1, 3'd4, 1, 5'd1,  5'd0, 5'd0,  0); // write to x0
        prog[6]  = mk(2'd0, 0, 0, 0, 0, 3'd0, 0, 5'd0,  5'd0, 5'd0,  0);
        prog[7]  = mk(2'd0, 0, 0, 0, 1, 3'd5, 0, 5'd0,  5'd0, 5'd6,  0);
        prog[8]  = mk(2'd1, 0, 0, 0, 1, 3'd0, 1, 5'd1,  5'd0, 5'd7,  0); // lw x7
        prog[9]  = mk(2'd0, 0, 0, 0, 1, 3'd6, 0, 5'd2,  5'd7, 5'd8,  0); // uses x7 via rs2
        prog[10] = mk(2'd0, 1, 0, 0, 0, 3'd1, 0, 5'd1,  5'd2, 5'd0,  1); // taken branch
        prog[11] = mk(2'd0, 0, 0, 0, 1, 3'd0, 1, 5'd1,  5'd0, 5'd9,  0); // squashed
        prog[12] = mk(2'd0, 1, 0, 0, 0, 3'd1, 0, 5'd8,  5'd8, 5'd0,  0); // not taken
        prog[13] = mk(2'd2, 0, 1, 0, 1, 3'd0, 0, 5'd0,  5'd0, 5'd1,  0); // jal, held in E
        prog[14] = mk(2'd0, 0, 0, 0, 1, 3'd0, 1, 5'd0,  5'd0, 5'd11, 0); // squashed
        prog[15] = mk(2'd0, 0, 0, 0, 1, 3'd7, 1, 5'd1,  5'd0, 5'd10, 0);
        prog[16] = mk(2'd1, 0, 0, 0, 1, 3'd0, 1, 5'd2,  5'd0, 5'd12, 0); // lw x12
        prog[17] = mk(2'd0, 0, 0, 1, 0, 3'd0, 0, 5'd12, 5'd3, 5'd0,  0); // uses x12 via rs1
        rd5 = mk(2'd0, 0, 0, 0, 1, 3'd2, 0, 5'd1, 5'd2, 5'd5, 0);

        model_reset();
        bus.i_result_src_d = '0; bus.i_branch_d = 0; bus.i_jmp_d = 0; bus.i_mem_write_d = 0;
        bus.i_reg_write_d = 0; bus.i_alu_ctl_d = '0; bus.i_alu_src_d = 0; bus.i_rs1_d = '0;
        bus.i_rs2_d = '0; bus.i_rd_d = '0; bus.i_zero_e = 0; bus.i_hold = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        idx = 0; dbub = 0; held_done = 0; hold_left = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            d = dbub ? bub : ((idx < N) ? prog[idx] : bub);
            if (hold_left == 0 && !held_done && q[1].jmp) begin
                hold_left = 4;
                held_done = 1;
            end
            h = (hold_left > 0);
            step(d, h, lw, pc);
            if (h) begin
                hold_left--;
            end else begin
                if (lw) n_stall++;
                if (pc) n_flush++;
                if (!lw) begin
                    if (!dbub && idx < N) idx++;
                    dbub = pc;
                end
            end
        end
        check_val("prog_done", 32'(idx), 32'(N));
        check_val("hold_seen", 32'(held_done), 1);

`ifdef PIPE_HAZ_PERF_CNT_EN
        check_val("stall_cnt", bus.o_stall_cnt, 32'(n_stall));
        check_val("flush_cnt", bus.o_flush_cnt, 32'(n_flush));
`endif

        // Mid-stream reset with a register write to x5 in flight.
        step(rd5, 0, lw, pc);
        step(rd5, 0, lw, pc);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(rd5, 0, lw, pc);
        check_val("post_reset_w_rd", 32'(bus.o_rd_w), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
